// File: rtl/inst_fetcher.sv
// inst_fetcher: PC owner and fetch sequencer feeding the decoder through a
// 16-line direct-mapped icache; refills from the memory controller.
// Ports: clk_in/rst_in/rdy_in; wrong_predicted/correct_pc redirect;
// issue_signal/next_pc from decoder; valid/inst/inst_addr to decoder;
// mem_req/mem_addr/mem_ready/mem_data to memory controller.
module inst_fetcher #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          ICACHE_IDX = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        wrong_predicted,
  input  logic [31:0] correct_pc,
  input  logic        issue_signal,
  input  logic [31:0] next_pc,
  output logic        valid,
  output logic [31:0] inst,
  output logic [31:0] inst_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_data
);

  localparam int LINES = 1 << ICACHE_IDX;
  localparam int TAG_W = 32 - ICACHE_IDX - 2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic [31:0]       inst_addr_q, inst_addr_d;
  logic              valid_q, valid_d;
  logic              mem_req_q, mem_req_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic              discard_q, discard_d;
  logic [LINES-1:0]  line_valid_q, line_valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [31:0]       data_q [LINES];

  logic [31:0]           lk_addr;
  logic [ICACHE_IDX-1:0] lk_idx;
  logic                  lk_hit;
  logic [ICACHE_IDX-1:0] fill_idx;
  logic                  fill_en;
  logic                  unused_lk_bits;

  // HOLD looks up the predicted next PC so a hit can issue back-to-back.
  assign lk_addr  = (state_q == HOLD) ? next_pc : pc_q;
  assign lk_idx   = lk_addr[ICACHE_IDX+1:2];
  assign lk_hit   = line_valid_q[lk_idx] &&
                    (tag_q[lk_idx] == lk_addr[31:ICACHE_IDX+2]);
  assign fill_idx = mem_addr_q[ICACHE_IDX+1:2];
  assign unused_lk_bits = ^lk_addr[1:0];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_addr_d  = inst_addr_q;
    valid_d      = valid_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    discard_d    = discard_q;
    line_valid_d = line_valid_q;
    fill_en      = 1'b0;
    if (rdy_in) begin
      unique case (state_q)
        IDLE: begin
          if (wrong_predicted) begin
            pc_d = correct_pc;
          end else if (lk_hit) begin
            inst_d      = data_q[lk_idx];
            inst_addr_d = pc_q;
            valid_d     = 1'b1;
            state_d     = HOLD;
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
            state_d    = BUSY;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            // The line is filled even when the data is dropped.
            fill_en   = 1'b1;
            mem_req_d = 1'b0;
            line_valid_d[fill_idx] = 1'b1;
            if (wrong_predicted || discard_q) begin
              discard_d = 1'b0;
              state_d   = IDLE;
              if (wrong_predicted) pc_d = correct_pc;
            end else begin
              inst_d      = mem_data;
              inst_addr_d = mem_addr_q;
              valid_d     = 1'b1;
              state_d     = HOLD;
            end
          end else if (wrong_predicted) begin
            // Request cannot be withdrawn; drop its response instead.
            discard_d = 1'b1;
            pc_d      = correct_pc;
          end
        end
        HOLD: begin
          if (wrong_predicted) begin
            pc_d    = correct_pc;
            valid_d = 1'b0;
            state_d = IDLE;
          end else if (issue_signal) begin
            pc_d = next_pc;
            if (lk_hit) begin
              inst_d      = data_q[lk_idx];
              inst_addr_d = next_pc;
            end else begin
              valid_d    = 1'b0;
              mem_req_d  = 1'b1;
              mem_addr_d = next_pc;
              state_d    = BUSY;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= 32'h0;
      inst_addr_q  <= 32'h0;
      valid_q      <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 32'h0;
      discard_q    <= 1'b0;
      line_valid_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_addr_q  <= inst_addr_d;
      valid_q      <= valid_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      discard_q    <= discard_d;
      line_valid_q <= line_valid_d;
    end
  end

  // Tag/data storage needs no reset; line_valid guards it.
  always_ff @(posedge clk_in) begin
    if (fill_en && !rst_in) begin
      tag_q[fill_idx]  <= mem_addr_q[31:ICACHE_IDX+2];
      data_q[fill_idx] <= mem_data;
    end
  end

  assign valid     = valid_q;
  assign inst      = inst_q;
  assign inst_addr = inst_addr_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: misses, cache replay, flushes,
// rdy_in freeze and reset during a refill.
module tb_inst_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        wrong_predicted;
  logic [31:0] correct_pc;
  logic        issue_signal;
  logic [31:0] next_pc;
  logic        valid;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;

  int n_chk = 0;
  int n_err = 0;

  inst_fetcher #(.RESET_PC(32'h0), .ICACHE_IDX(4)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .wrong_predicted(wrong_predicted),
    .correct_pc(correct_pc),
    .issue_signal(issue_signal),
    .next_pc(next_pc),
    .valid(valid),
    .inst(inst),
    .inst_addr(inst_addr),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ready(mem_ready),
    .mem_data(mem_data)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 8) | 32'h13;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Request for addr is pending now; answer after lat cycles.
  task automatic serve(input logic [31:0] addr, input int lat);
    chk("req_pend", {31'b0, mem_req}, 32'd1);
    chk("req_addr", mem_addr, addr);
    repeat (lat - 1) step();
    mem_ready = 1'b1;
    mem_data  = mem_word(addr);
    step();
    mem_ready = 1'b0;
    mem_data  = 32'h0;
    chk("fill_valid", {31'b0, valid}, 32'd1);
    chk("fill_inst", inst, mem_word(addr));
    chk("fill_iaddr", inst_addr, addr);
    chk("fill_req_drop", {31'b0, mem_req}, 32'd0);
  endtask

  task automatic issue(input logic [31:0] npc);
    issue_signal = 1'b1;
    next_pc      = npc;
    step();
    issue_signal = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    wrong_predicted = 1'b0;
    correct_pc = 32'h0;
    issue_signal = 1'b0;
    next_pc = 32'h0;
    mem_ready = 1'b0;
    mem_data = 32'h0;
    step();
    step();
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_iaddr", inst_addr, 32'h0);
    rst_in = 1'b0;
    step();
    serve(32'h0, 3);
    step();
    chk("hold_valid", {31'b0, valid}, 32'd1);
    chk("hold_iaddr", inst_addr, 32'h0);

    // Sequential misses
    issue(32'h4);
    chk("miss4_valid", {31'b0, valid}, 32'd0);
    serve(32'h4, 3);
    issue(32'h8);
    serve(32'h8, 3);

    // Loop replay from cache, back-to-back
    issue_signal = 1'b1;
    next_pc = 32'h0;
    step();
    chk("replay0_inst", inst, 32'h13);
    chk("replay0_req", {31'b0, mem_req}, 32'd0);
    next_pc = 32'h4;
    step();
    chk("replay4_inst", inst, 32'h413);
    chk("replay4_iaddr", inst_addr, 32'h4);
    next_pc = 32'h8;
    step();
    chk("replay8_inst", inst, 32'h813);
    chk("replay8_valid", {31'b0, valid}, 32'd1);
    issue(32'h40);
    chk("m40_req", {31'b0, mem_req}, 32'd1);
    chk("m40_addr", mem_addr, 32'h40);

    // Flush while BUSY: response for 0x40 dropped
    wrong_predicted = 1'b1;
    correct_pc = 32'h100;
    step();
    wrong_predicted = 1'b0;
    chk("fl_valid", {31'b0, valid}, 32'd0);
    chk("fl_req_kept", {31'b0, mem_req}, 32'd1);
    chk("fl_addr_kept", mem_addr, 32'h40);
    step();
    mem_ready = 1'b1;
    mem_data = mem_word(32'h40);
    step();
    mem_ready = 1'b0;
    chk("drop_valid", {31'b0, valid}, 32'd0);
    chk("drop_req", {31'b0, mem_req}, 32'd0);
    step();
    serve(32'h100, 2);

    // Issue and flush together in HOLD
    issue_signal = 1'b1;
    next_pc = 32'h4;
    wrong_predicted = 1'b1;
    correct_pc = 32'h8;
    step();
    issue_signal = 1'b0;
    wrong_predicted = 1'b0;
    chk("if_valid", {31'b0, valid}, 32'd0);
    chk("if_req", {31'b0, mem_req}, 32'd0);
    step();
    chk("if_hit_valid", {31'b0, valid}, 32'd1);
    chk("if_hit_iaddr", inst_addr, 32'h8);
    chk("if_hit_inst", inst, 32'h813);

    // Flush in the same cycle as mem_ready
    issue(32'h48);
    chk("m48_addr", mem_addr, 32'h48);
    mem_ready = 1'b1;
    mem_data = mem_word(32'h48);
    wrong_predicted = 1'b1;
    correct_pc = 32'hC;
    step();
    mem_ready = 1'b0;
    wrong_predicted = 1'b0;
    chk("flr_valid", {31'b0, valid}, 32'd0);
    chk("flr_req", {31'b0, mem_req}, 32'd0);
    step();
    serve(32'hC, 1);
    issue(32'h48);
    chk("h48_valid", {31'b0, valid}, 32'd1);
    chk("h48_inst", inst, 32'h4813);
    chk("h48_req", {31'b0, mem_req}, 32'd0);

    // rdy_in freeze
    issue(32'h80);
    chk("m80_addr", mem_addr, 32'h80);
    rdy_in = 1'b0;
    mem_ready = 1'b1;
    mem_data = mem_word(32'h80);
    wrong_predicted = 1'b1;
    correct_pc = 32'h200;
    issue_signal = 1'b1;
    next_pc = 32'h300;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("frz_valid", {31'b0, valid}, 32'd0);
      chk("frz_req", {31'b0, mem_req}, 32'd1);
      chk("frz_addr", mem_addr, 32'h80);
    end
    rdy_in = 1'b1;
    mem_ready = 1'b0;
    wrong_predicted = 1'b0;
    issue_signal = 1'b0;
    step();
    chk("thaw_valid", {31'b0, valid}, 32'd0);
    serve(32'h80, 1);

    // Reset during a refill
    issue(32'h200);
    chk("m200_req", {31'b0, mem_req}, 32'd1);
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    chk("rstb_req", {31'b0, mem_req}, 32'd0);
    chk("rstb_valid", {31'b0, valid}, 32'd0);
    step();
    chk("rstb_rereq", {31'b0, mem_req}, 32'd1);
    chk("rstb_addr", mem_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
